// File: rtl/pipe_stall_ctrl_if.sv
// Interface bundle between the ID hazard unit / CP0 / MDU and the pipeline stall controller.
// The master drives the hazard and exception requests; the slave (the controller) returns the pipeline controls.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stall_data;
  logic             id_is_md;
  logic             ex_md_start;
  logic             ex_md_div;
  logic             exc_req;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_flush;
  logic             req;
  logic             md_start_gated;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output stall_data, id_is_md, ex_md_start, ex_md_div, exc_req,
    input  pc_en, if_id_en, id_ex_flush, req, md_start_gated, md_busy, stall_cnt
  );

  modport slave (
    input  stall_data, id_is_md, ex_md_start, ex_md_div, exc_req,
    output pc_en, if_id_en, id_ex_flush, req, md_start_gated, md_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush/request controller for the five-stage pipeline: merges data-hazard stalls,
// the MDU busy countdown and CP0 exception requests, and counts stalled cycles.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stall_ctrl_if.slave  bus
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [3:0]       MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0]       DIV_LD  = 4'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       busy_cnt_q, busy_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  md_state_e        md_state;
  logic             md_start;
  logic             md_stall;
  logic             stall;

  // The MDU state is derived from the countdown itself; zero means idle.
  always_comb begin
    md_state = (busy_cnt_q != 4'd0) ? MD_BUSY : MD_IDLE;
    md_start = bus.ex_md_start & ~bus.exc_req;
    md_stall = bus.id_is_md & ((md_state == MD_BUSY) | bus.ex_md_start);
    stall    = bus.stall_data | md_stall;
  end

  always_comb begin
    busy_cnt_d  = busy_cnt_q;
    stall_cnt_d = stall_cnt_q;

    // A start while already busy reloads the counter: the newest operation wins.
    if (md_start) begin
      busy_cnt_d = bus.ex_md_div ? DIV_LD : MULT_LD;
    end else begin
      case (md_state)
        MD_BUSY: busy_cnt_d = busy_cnt_q - 4'd1;
        default: busy_cnt_d = busy_cnt_q;
      endcase
    end

    if (stall && !bus.exc_req && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt_q  <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // An exception request overrides any stall so every pipeline register can clear itself.
  assign bus.req            = bus.exc_req;
  assign bus.pc_en          = bus.exc_req | ~stall;
  assign bus.if_id_en       = bus.exc_req | ~stall;
  assign bus.id_ex_flush    = ~bus.exc_req & stall;
  assign bus.md_start_gated = md_start;
  assign bus.md_busy        = (md_state == MD_BUSY);
  assign bus.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios followed by random stimulus,
// checked against a cycle-numbered reference model of the stall rules.
module tb_pipe_stall_ctrl;

  localparam int CNT_W   = 4;
  localparam int MULT_N  = 5;
  localparam int DIV_N   = 10;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic clk;
  logic reset;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int pc_en;
    int if_id_en;
    int id_ex_flush;
    int req;
    int md_start_gated;
    int md_busy;
    int stall_cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the MDU is busy on every cycle up to and including busy_until.
  int cyc        = 0;
  int busy_until = -1;
  int cnt_m      = 0;

  task automatic chk(input string name, input int id, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL txn %0d %s: got %0d expected %0d", id, name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc_en",          e.id, int'(bus.pc_en),          e.pc_en);
      chk("if_id_en",       e.id, int'(bus.if_id_en),       e.if_id_en);
      chk("id_ex_flush",    e.id, int'(bus.id_ex_flush),    e.id_ex_flush);
      chk("req",            e.id, int'(bus.req),            e.req);
      chk("md_start_gated", e.id, int'(bus.md_start_gated), e.md_start_gated);
      chk("md_busy",        e.id, int'(bus.md_busy),        e.md_busy);
      chk("stall_cnt",      e.id, int'(bus.stall_cnt),      e.stall_cnt);
      $display("txn %0d: pc_en=%0d flush=%0d req=%0d busy=%0d cnt=%0d", e.id,
               bus.pc_en, bus.id_ex_flush, bus.req, bus.md_busy, bus.stall_cnt);
    end
  end

  // Drive one cycle of inputs, record what the pipeline should see, advance the model.
  task automatic step(input logic r, input logic sd, input logic md, input logic st,
                      input logic dv, input logic ex);
    exp_t e;
    int   busy;
    int   stall_e;
    reset           = r;
    bus.stall_data  = sd;
    bus.id_is_md    = md;
    bus.ex_md_start = st;
    bus.ex_md_div   = dv;
    bus.exc_req     = ex;

    busy    = (cyc <= busy_until) ? 1 : 0;
    stall_e = (sd || (md && (busy == 1 || st))) ? 1 : 0;
    e.id             = cyc;
    e.req            = int'(ex);
    e.pc_en          = ex ? 1 : 1 - stall_e;
    e.if_id_en       = ex ? 1 : 1 - stall_e;
    e.id_ex_flush    = ex ? 0 : stall_e;
    e.md_start_gated = (st && !ex) ? 1 : 0;
    e.md_busy        = busy;
    e.stall_cnt      = cnt_m;
    sb.push_back(e);

    if (r) begin
      busy_until = cyc;
      cnt_m      = 0;
    end else begin
      if (st && !ex) busy_until = cyc + (dv ? DIV_N : MULT_N);
      if (stall_e == 1 && !ex && cnt_m < CNT_TOP) cnt_m = cnt_m + 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    bus.stall_data  = 1'b0;
    bus.id_is_md    = 1'b0;
    bus.ex_md_start = 1'b0;
    bus.ex_md_div   = 1'b0;
    bus.exc_req     = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset then idle
    step(0, 0, 0, 0, 0, 0);
    // Data hazard for 3 cycles
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Mult followed by an MD instruction held in ID
    step(0, 0, 1, 1, 0, 0);
    repeat (6) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Div with an exception three cycles in
    step(0, 0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    repeat (9) step(0, 0, 0, 0, 0, 0);
    // Exception coinciding with start
    step(0, 0, 1, 1, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    // Reset mid-div
    step(0, 0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    // Counter saturation
    repeat (20) step(0, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush/request controller for the five-stage MIPS pipeline.
- Combines ID-stage data-hazard stalls, the multiply/divide unit (MDU) busy sequence and CP0 exception requests.
- Produces the enable, flush and req controls for the PC register, IF/ID, ID/EX and the later pipeline registers.
- Owns the MDU busy countdown and a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles loaded for div/divu (1..15)
- CNT_W, 32, width of stall performance counter

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- stall_data  input  1  combinational data-hazard stall from the ID hazard unit
- id_is_md  input  1  ID instr is mult/div/mfhi/mflo/mthi/mtlo
- ex_md_start  input  1  EX instr is mult/multu/div/divu (start pulse)
- ex_md_div  input  1  with ex_md_start: 1 = div class, 0 = mult class
- exc_req  input  1  exception/interrupt request from CP0
- pc_en  output  1  PC register write enable
- if_id_en  output  1  IF/ID enable
- id_ex_flush  output  1  ID/EX bubble insert
- req  output  1  broadcast request to all pipeline registers and PC (forces 0x4180)
- md_start_gated  output  1  start to MDU datapath = ex_md_start & ~exc_req
- md_busy  output  1  MDU operation in progress
- stall_cnt  output  CNT_W  count of stall cycles since reset

Behaviour:
- Clocking and reset:
  - One clock; all state updates on posedge clk.
  - reset has priority over every other input.
  - During and after reset: busy_cnt = 0, md_busy = 0, stall_cnt = 0.
  - With inputs idle: pc_en = 1, if_id_en = 1, id_ex_flush = 0, req = 0.
- State: 4-bit busy_cnt; IDLE when busy_cnt == 0, BUSY otherwise; md_busy = (busy_cnt != 0), registered.
- IDLE -> BUSY: on md_start_gated, load busy_cnt = ex_md_div ? DIV_CYCLES : MULT_CYCLES.
- BUSY: busy_cnt decrements by 1 each cycle and returns to IDLE when it reaches 0. With MULT_CYCLES = 5, md_busy is high exactly 5 cycles starting the cycle after the start.
- md_start_gated while BUSY must not occur because the stall prevents it. If it does occur, the counter reloads (last start wins).
- md_stall = id_is_md & (md_busy | ex_md_start), combinational.
- stall = stall_data | md_stall.
- Outputs are combinational from the current state and inputs:
  - req = exc_req.
  - If req: pc_en = 1, if_id_en = 1, id_ex_flush = 0. Req overrides stall and every pipeline register clears itself.
  - Else: pc_en = ~stall, if_id_en = ~stall, id_ex_flush = stall.
- An exception does not abort an in-flight MDU operation; busy_cnt keeps counting.
- exc_req in the same cycle as ex_md_start: md_start_gated = 0 and no load occurs, since the victim instruction must not execute.
- stall_cnt increments by 1 on every non-reset cycle with stall & ~req. It saturates at all-ones with no wrap.
- Reset mid-operation (BUSY): busy_cnt is cleared on the next edge, and md_busy is 0 the following cycle.
- Stall of arbitrary length: the outputs hold steady and the counter keeps decrementing independently.

Test Plan:
- Reset then idle: reset = 1 for 2 cycles, then all inputs 0 -> pc_en = 1, if_id_en = 1, id_ex_flush = 0, req = 0, md_busy = 0, stall_cnt = 0.
- Data hazard: stall_data = 1 for 3 cycles -> pc_en = if_id_en = 0 and id_ex_flush = 1 in exactly those cycles; stall_cnt = 3 afterwards.
- Mult then mfhi:
  - Stimulus: ex_md_start = 1, ex_md_div = 0 at cycle t; id_is_md held 1.
  - Stall at cycle t (start-cycle term), md_busy high for t+1..t+5, stall through t+5.
  - pc_en = 1 at t+6; stall_cnt = 6.
- Div with exception mid-busy: div start at t, exc_req = 1 at t+3 -> req = 1, pc_en = 1, id_ex_flush = 0 at t+3; md_busy stays high through t+10 and falls at t+11.
- Exception coinciding with start: ex_md_start = 1 and exc_req = 1 in the same cycle -> md_start_gated = 0 and md_busy stays 0.
- Reset mid-busy and saturation:
  - Div start, then reset at t+4 -> md_busy = 0 at t+5.
  - With CNT_W = 4 and stall_data held 20 cycles -> stall_cnt = 15 and holds.
